// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if
//   Bundles the three requester handshakes (fetch, data, stack) and the
//   shared memory port that mem_port_arbiter sits between.
//   slave  : arbiter side (takes requests and mem_rdata, drives done/rdata/mem_*)
//   master : datapath/memory side (the mirror image)
interface mem_port_arbiter_if;
  // fetch requester
  logic        f_req;
  logic [31:0] f_addr;
  logic        f_done;
  // data load/store requester
  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic        d_done;
  // stack push/pop requester
  logic        s_req;
  logic        s_we;
  logic [31:0] s_addr;
  logic [31:0] s_wdata;
  logic        s_done;
  // shared response / status
  logic [31:0] rdata;
  logic        busy;
  // memory port
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_re;
  logic        mem_we;
  logic [31:0] mem_rdata;

  modport slave (
    input  f_req, f_addr,
    input  d_req, d_we, d_addr, d_wdata,
    input  s_req, s_we, s_addr, s_wdata,
    input  mem_rdata,
    output f_done, d_done, s_done, rdata, busy,
    output mem_addr, mem_wdata, mem_re, mem_we
  );

  modport master (
    output f_req, f_addr,
    output d_req, d_we, d_addr, d_wdata,
    output s_req, s_we, s_addr, s_wdata,
    output mem_rdata,
    input  f_done, d_done, s_done, rdata, busy,
    input  mem_addr, mem_wdata, mem_re, mem_we
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one 32-bit fixed-latency memory port between fetch (F), data (D)
//   and stack (S) requesters. One transaction in flight; IDLE -> ISSUE -> WAIT.
//   Fixed priority D > S > F, except fetch is forced to win once it has lost
//   STARVE_MAX consecutive arbitrations.
//   Params: MEM_LAT (1..15) memory read latency, STARVE_MAX (1..15).
//   Ports : clk, rst_n (async, active low), bus (mem_port_arbiter_if.slave).
module mem_port_arbiter #(
  parameter int unsigned MEM_LAT    = 1,
  parameter int unsigned STARVE_MAX = 4
) (
  input logic              clk,
  input logic              rst_n,
  mem_port_arbiter_if.slave bus
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] WAIT  = 2'd2;

  localparam logic [1:0] ID_F = 2'd0;
  localparam logic [1:0] ID_D = 2'd1;
  localparam logic [1:0] ID_S = 2'd2;

  localparam logic [3:0] LAT = MEM_LAT[3:0];
  localparam logic [3:0] CAP = STARVE_MAX[3:0];

  typedef struct packed {
    logic [1:0]  id;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } req_t;

  logic [1:0]  state;
  req_t        cur;        // latched winner; also drives mem_addr/mem_wdata
  req_t        win;
  logic        anyReq;
  logic        fWins;
  logic        fEff, dEff, sEff;
  logic [3:0]  latCnt;
  logic [3:0]  starveCnt;
  logic        fDone, dDone, sDone;
  logic [31:0] rdataQ;
  logic        memRe, memWe;

  // Mask each request with its own done pulse: a requester sees done in the
  // same cycle it may still be holding req, and must not be granted again.
  always_comb begin
    fEff   = bus.f_req & ~fDone;
    dEff   = bus.d_req & ~dDone;
    sEff   = bus.s_req & ~sDone;
    win    = '0;
    anyReq = 1'b0;
    fWins  = 1'b0;
    if (fEff && starveCnt == CAP) begin
      win.id   = ID_F;
      win.addr = bus.f_addr;
      fWins    = 1'b1;
      anyReq   = 1'b1;
    end else if (dEff) begin
      win.id    = ID_D;
      win.we    = bus.d_we;
      win.addr  = bus.d_addr;
      win.wdata = bus.d_wdata;
      anyReq    = 1'b1;
    end else if (sEff) begin
      win.id    = ID_S;
      win.we    = bus.s_we;
      win.addr  = bus.s_addr;
      win.wdata = bus.s_wdata;
      anyReq    = 1'b1;
    end else if (fEff) begin
      win.id   = ID_F;
      win.addr = bus.f_addr;
      fWins    = 1'b1;
      anyReq   = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cur       <= '0;
      latCnt    <= '0;
      starveCnt <= '0;
      fDone     <= 1'b0;
      dDone     <= 1'b0;
      sDone     <= 1'b0;
      rdataQ    <= '0;
      memRe     <= 1'b0;
      memWe     <= 1'b0;
    end else begin
      fDone <= 1'b0;
      dDone <= 1'b0;
      sDone <= 1'b0;
      case (state)
        IDLE: begin
          if (anyReq) begin
            cur   <= win;
            // strobes are registered here so they are high during ISSUE
            memRe <= ~win.we;
            memWe <= win.we;
            state <= ISSUE;
            if (fEff) begin
              if (fWins)
                starveCnt <= '0;
              else if (starveCnt != CAP)
                starveCnt <= starveCnt + 4'd1;
            end
          end
        end
        ISSUE: begin
          memRe  <= 1'b0;
          memWe  <= 1'b0;
          latCnt <= LAT;
          state  <= WAIT;
        end
        WAIT: begin
          latCnt <= latCnt - 4'd1;
          if (latCnt == 4'd1) begin
            if (!cur.we)
              rdataQ <= bus.mem_rdata;
            fDone <= (cur.id == ID_F);
            dDone <= (cur.id == ID_D);
            sDone <= (cur.id == ID_S);
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.f_done    = fDone;
  assign bus.d_done    = dDone;
  assign bus.s_done    = sDone;
  assign bus.rdata     = rdataQ;
  assign bus.busy      = (state != IDLE);
  assign bus.mem_addr  = cur.addr;
  assign bus.mem_wdata = cur.wdata;
  assign bus.mem_re    = memRe;
  assign bus.mem_we    = memWe;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter
//   Directed bench for mem_port_arbiter. u1: MEM_LAT=1, STARVE_MAX=2;
//   u2: MEM_LAT=3. Each bus has a memory model that only presents read data
//   in the exact cycle the arbiter is meant to sample it.
//   Inputs are driven and outputs sampled on the falling edge.
module tb_mem_port_arbiter;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;
  bit   epoch  = 1'b0;   // flips the word at 0x40 to model fresh data

  always #5 clk = ~clk;

  mem_port_arbiter_if b1 ();
  mem_port_arbiter_if b2 ();

  mem_port_arbiter #(.MEM_LAT(1), .STARVE_MAX(2)) u1 (.clk(clk), .rst_n(rst_n), .bus(b1));
  mem_port_arbiter #(.MEM_LAT(3), .STARVE_MAX(4)) u2 (.clk(clk), .rst_n(rst_n), .bus(b2));

  // ---------------- memory models ----------------
  function automatic logic [31:0] word(input logic [31:0] a, input bit ep);
    case (a)
      32'h40:  word = ep ? 32'hCAFEF00D : 32'h8C220004;
      32'h100: word = 32'h11112222;
      32'h8:   word = 32'h33334444;
      32'h20:  word = 32'h5A5AA5A5;
      default: word = a ^ 32'hA5A50000;
    endcase
  endfunction

  logic [3:0]  rc1 = '0, rc2 = '0;
  logic [31:0] rb1 = '0, rb2 = '0;
  logic        wv  = 1'b0;
  logic [31:0] wA  = '0, wD = '0;

  always @(posedge clk) begin
    if (b1.mem_we) begin
      wv <= 1'b1;
      wA <= b1.mem_addr;
      wD <= b1.mem_wdata;
    end
    if (b1.mem_re) begin
      rc1 <= 4'd1;
      rb1 <= (wv && wA == b1.mem_addr) ? wD : word(b1.mem_addr, epoch);
    end else if (rc1 != 4'd0) rc1 <= rc1 - 4'd1;
    if (b2.mem_re) begin
      rc2 <= 4'd3;
      rb2 <= word(b2.mem_addr, epoch);
    end else if (rc2 != 4'd0) rc2 <= rc2 - 4'd1;
  end

  assign b1.mem_rdata = (rc1 == 4'd1) ? rb1 : 32'hBAD0BAD0;
  assign b2.mem_rdata = (rc2 == 4'd1) ? rb2 : 32'hBAD0BAD0;

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({b1.busy, b1.f_done, b1.d_done, b1.s_done, b1.mem_re, b1.mem_we,
         b1.mem_addr, b1.mem_wdata, b1.rdata} !== '0) begin
      errors++;
      $display("FAIL reset_u1: busy=%b dones=%b%b%b re=%b we=%b addr=%h wdata=%h rdata=%h, want all 0",
               b1.busy, b1.f_done, b1.d_done, b1.s_done, b1.mem_re, b1.mem_we,
               b1.mem_addr, b1.mem_wdata, b1.rdata);
    end
    checks++;
    if ({b2.busy, b2.f_done, b2.d_done, b2.s_done, b2.mem_re, b2.mem_we,
         b2.mem_addr, b2.mem_wdata, b2.rdata} !== '0) begin
      errors++;
      $display("FAIL reset_u2: outputs not all zero (busy=%b addr=%h rdata=%h)",
               b2.busy, b2.mem_addr, b2.rdata);
    end
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (u1.starveCnt !== 4'd0 || b1.busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle: starve=%0d busy=%b, want 0 0", u1.starveCnt, b1.busy);
    end
  endtask

  task automatic test_single_fetch();
    // cycle 0
    b1.f_req = 1'b1; b1.f_addr = 32'h40;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      checks++;
      if (b1.mem_re !== (k == 1) || b1.mem_we !== 1'b0) begin
        errors++;
        $display("FAIL fetch_strobe c%0d: re=%b we=%b, want re=%b we=0", k, b1.mem_re, b1.mem_we, k == 1);
      end
      checks++;
      if (b1.f_done !== (k == 3) || b1.busy !== (k == 1 || k == 2)) begin
        errors++;
        $display("FAIL fetch_done c%0d: done=%b busy=%b, want %b %b", k, b1.f_done, b1.busy,
                 k == 3, k == 1 || k == 2);
      end
      if (k == 1) begin
        checks++;
        if (b1.mem_addr !== 32'h40) begin
          errors++;
          $display("FAIL fetch_addr: got %h want 00000040", b1.mem_addr);
        end
      end
      if (k == 3) begin
        checks++;
        if (b1.rdata !== 32'h8C220004) begin
          errors++;
          $display("FAIL fetch_rdata: got %h want 8c220004", b1.rdata);
        end
        b1.f_req = 1'b0;
      end
    end
  endtask

  task automatic test_simultaneous();
    b1.d_req = 1'b1; b1.d_we = 1'b0; b1.d_addr = 32'h100; b1.d_wdata = 32'hDEAD0000;
    b1.s_req = 1'b1; b1.s_we = 1'b1; b1.s_addr = 32'h1FC; b1.s_wdata = 32'h44;
    b1.f_req = 1'b1; b1.f_addr = 32'h8;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      checks++;
      if ({b1.d_done, b1.s_done, b1.f_done} !== {k == 3, k == 6, k == 9}) begin
        errors++;
        $display("FAIL sim_done c%0d: dsf=%b%b%b, want %b%b%b", k, b1.d_done, b1.s_done, b1.f_done,
                 k == 3, k == 6, k == 9);
      end
      checks++;
      if (b1.mem_re !== (k == 1 || k == 7) || b1.mem_we !== (k == 4)) begin
        errors++;
        $display("FAIL sim_strobe c%0d: re=%b we=%b", k, b1.mem_re, b1.mem_we);
      end
      checks++;
      if (b1.busy !== (k != 3 && k != 6 && k != 9 && k != 10)) begin
        errors++;
        $display("FAIL sim_busy c%0d: got %b", k, b1.busy);
      end
      if (k == 1 || k == 4 || k == 7) begin
        checks++;
        if (b1.mem_addr !== (k == 1 ? 32'h100 : k == 4 ? 32'h1FC : 32'h8)) begin
          errors++;
          $display("FAIL sim_grant c%0d: addr=%h", k, b1.mem_addr);
        end
      end
      if (k == 4) begin
        checks++;
        if (b1.mem_wdata !== 32'h44) begin
          errors++;
          $display("FAIL sim_wdata: got %h want 00000044", b1.mem_wdata);
        end
      end
      if (k == 3 || k == 6 || k == 9) begin
        checks++;
        if (b1.rdata !== (k == 9 ? 32'h33334444 : 32'h11112222)) begin
          errors++;
          $display("FAIL sim_rdata c%0d: got %h", k, b1.rdata);
        end
      end
      if (k == 3) b1.d_req = 1'b0;
      if (k == 6) b1.s_req = 1'b0;
      if (k == 9) b1.f_req = 1'b0;
    end
    checks++;
    if (wv !== 1'b1 || wA !== 32'h1FC || wD !== 32'h44 || u1.starveCnt !== 4'd0) begin
      errors++;
      $display("FAIL sim_push: wv=%b addr=%h data=%h starve=%0d, want 1 1fc 44 0",
               wv, wA, wD, u1.starveCnt);
    end
  endtask

  task automatic test_starvation();
    b1.d_req = 1'b1; b1.d_we = 1'b0; b1.d_addr = 32'h100;
    b1.s_req = 1'b1; b1.s_we = 1'b0; b1.s_addr = 32'h1FC;
    b1.f_req = 1'b1; b1.f_addr = 32'h8;
    for (int k = 1; k <= 13; k++) begin
      @(negedge clk);
      checks++;
      if ({b1.d_done, b1.s_done, b1.f_done} !== {k == 3 || k == 12, k == 6, k == 9}) begin
        errors++;
        $display("FAIL starve_done c%0d: dsf=%b%b%b", k, b1.d_done, b1.s_done, b1.f_done);
      end
      if (k == 1 || k == 4 || k == 7 || k == 10) begin
        checks++;
        if (b1.mem_addr !== (k == 4 ? 32'h1FC : k == 7 ? 32'h8 : 32'h100)) begin
          errors++;
          $display("FAIL starve_grant c%0d: addr=%h", k, b1.mem_addr);
        end
        checks++;
        if (u1.starveCnt !== (k == 1 ? 4'd1 : k == 4 ? 4'd2 : 4'd0)) begin
          errors++;
          $display("FAIL starve_cnt c%0d: got %0d", k, u1.starveCnt);
        end
      end
      if (k == 6) begin
        checks++;
        if (b1.rdata !== 32'h44) begin
          errors++;
          $display("FAIL starve_pop: got %h want 00000044", b1.rdata);
        end
        b1.s_req = 1'b0;
      end
      if (k == 9)  b1.f_req = 1'b0;
      if (k == 12) b1.d_req = 1'b0;
    end
  endtask

  task automatic test_latency();
    b2.d_req = 1'b1; b2.d_we = 1'b0; b2.d_addr = 32'h20;
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk);
      checks++;
      if (b2.mem_re !== (k == 1) || b2.mem_we !== 1'b0) begin
        errors++;
        $display("FAIL lat_strobe c%0d: re=%b we=%b", k, b2.mem_re, b2.mem_we);
      end
      checks++;
      if (b2.d_done !== (k == 5) || b2.busy !== (k >= 1 && k <= 4)) begin
        errors++;
        $display("FAIL lat_done c%0d: done=%b busy=%b", k, b2.d_done, b2.busy);
      end
      if (k <= 5) begin
        checks++;
        if (b2.mem_addr !== 32'h20) begin
          errors++;
          $display("FAIL lat_addr c%0d: got %h want 00000020", k, b2.mem_addr);
        end
      end
      if (k == 5) begin
        checks++;
        if (b2.rdata !== 32'h5A5AA5A5) begin
          errors++;
          $display("FAIL lat_rdata: got %h want 5a5aa5a5", b2.rdata);
        end
        b2.d_req = 1'b0;
      end
    end
  endtask

  task automatic test_reset_mid();
    b1.f_req = 1'b1; b1.f_addr = 32'h40;
    @(negedge clk);
    checks++;
    if (b1.mem_re !== 1'b1) begin
      errors++;
      $display("FAIL rmid_issue: re=%b want 1", b1.mem_re);
    end
    @(negedge clk);   // WAIT
    checks++;
    if (b1.busy !== 1'b1) begin
      errors++;
      $display("FAIL rmid_wait: busy=%b want 1", b1.busy);
    end
    rst_n = 1'b0;
    epoch = 1'b1;
    #1;
    checks++;
    if ({b1.busy, b1.f_done, b1.mem_re, b1.mem_we, b1.mem_addr, b1.rdata} !== '0) begin
      errors++;
      $display("FAIL rmid_async: busy=%b done=%b re=%b addr=%h rdata=%h, want all 0",
               b1.busy, b1.f_done, b1.mem_re, b1.mem_addr, b1.rdata);
    end
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checks++;
      if (b1.f_done !== 1'b0 || b1.busy !== 1'b0) begin
        errors++;
        $display("FAIL rmid_held c%0d: done=%b busy=%b", k, b1.f_done, b1.busy);
      end
    end
    rst_n = 1'b1;   // f_req still held: this is arbitration cycle 0
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      checks++;
      if (b1.mem_re !== (k == 1) || b1.f_done !== (k == 3)) begin
        errors++;
        $display("FAIL rmid_after c%0d: re=%b done=%b", k, b1.mem_re, b1.f_done);
      end
      if (k == 3) begin
        checks++;
        if (b1.rdata !== 32'hCAFEF00D) begin
          errors++;
          $display("FAIL rmid_rdata: got %h want cafef00d", b1.rdata);
        end
        b1.f_req = 1'b0;
      end
    end
  endtask

  initial begin
    b1.f_req = 1'b0; b1.f_addr = '0;
    b1.d_req = 1'b0; b1.d_we = 1'b0; b1.d_addr = '0; b1.d_wdata = '0;
    b1.s_req = 1'b0; b1.s_we = 1'b0; b1.s_addr = '0; b1.s_wdata = '0;
    b2.f_req = 1'b0; b2.f_addr = '0;
    b2.d_req = 1'b0; b2.d_we = 1'b0; b2.d_addr = '0; b2.d_wdata = '0;
    b2.s_req = 1'b0; b2.s_we = 1'b0; b2.s_addr = '0; b2.s_wdata = '0;
    test_reset();
    test_single_fetch();
    test_simultaneous();
    test_starvation();
    test_latency();
    test_reset_mid();
    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares the single 32-bit data memory port between three requesters of the processor datapath: instruction fetch (F), data load/store (D) and stack push/pop for call/return (S). One transaction is in flight at a time; a fixed-latency memory is sequenced by a 3-state FSM. Fixed priority D > S > F is used, with a starvation counter that guarantees fetch forward progress. Sits between the datapath's PC/SP/ALU address muxes and the `memory` instance.

## Interface

- `MEM_LAT`, 1: memory read latency in cycles, legal range 1..15.
- `STARVE_MAX`, 4: consecutive lost arbitrations after which fetch is forced to win, legal range 1..15.

- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `f_req` in 1: fetch read request, held until `f_done`.
- `f_addr` in 32: fetch address (PC).
- `d_req` in 1: data request, held until `d_done`.
- `d_we` in 1: 1 = store, 0 = load.
- `d_addr` in 32: data address (ALU result).
- `d_wdata` in 32: store data.
- `s_req` in 1: stack request, held until `s_done`.
- `s_we` in 1: 1 = push, 0 = pop.
- `s_addr` in 32: stack address (SP ± 4).
- `s_wdata` in 32: push data (return PC).
- `f_done`, `d_done`, `s_done` out 1: one-cycle completion pulses.
- `rdata` out 32: registered read data, valid while any `*_done` is high.
- `busy` out 1: high whenever the FSM is not IDLE.
- `mem_addr` out 32, `mem_wdata` out 32: registered memory address and write data.
- `mem_re` out 1, `mem_we` out 1: one-cycle memory strobes.
- `mem_rdata` in 32: memory read data.

## Operation

- Reset (async, `rst_n`=0): state IDLE. All outputs 0, starvation count 0, latency counter 0. Any in-flight response is discarded and no `*_done` is issued for it.
- State IDLE:
  - Effective requests are `x_req` masked by `x_done` of the current cycle, so a requester dropping `req` late is not re-granted.
  - Winner if starve count = `STARVE_MAX` and `f_req`: F. Otherwise D, then S, then F.
  - On any winner: latch id, address, wdata and we (F forced we=0). Go to ISSUE.
- State ISSUE, exactly one cycle:
  - `mem_addr`/`mem_wdata` are driven from the latch; `mem_re` = !we, `mem_we` = we.
  - Latency counter is loaded with `MEM_LAT`. Go to WAIT.
- State WAIT:
  - Counter decrements each cycle. Strobes are low; `mem_addr` holds.
  - When counter = 1: capture `mem_rdata` into `rdata` (reads only; writes leave `rdata` unchanged). Go to IDLE.
  - The next cycle pulses the winner's `*_done`.
- Starvation counter, updated on each IDLE arbitration:
  - `f_req` high and F loses: +1, saturating at `STARVE_MAX`.
  - F wins: cleared to 0.
  - `f_req` low: unchanged.
- Writes use the same timing as reads, giving uniform completion.
- Requests that change address or we while pending but not yet granted are legal. Values are sampled at the arbitration cycle.

## Timing

- Arbitration is at cycle T (IDLE with a request). ISSUE is T+1. `mem_rdata` is sampled at the end of cycle T+1+`MEM_LAT`. `*_done`/`rdata` are valid in cycle T+2+`MEM_LAT`, which is also an IDLE arbitration cycle.
- Request-to-done is `MEM_LAT`+2 cycles (3 for `MEM_LAT`=1). Back-to-back throughput is one transaction per `MEM_LAT`+2 cycles.
- Simultaneous `d_req`, `s_req` and `f_req` in IDLE: D is granted, then S, then F, with no idle gap between transactions.
- `rst_n` asserted in ISSUE or WAIT clears the strobes immediately (asynchronously). After release, the first arbitration occurs on the first rising edge with `rst_n`=1.
- `busy` = 1 in ISSUE and WAIT. `busy` = 0 in IDLE, including the done cycle.

## Test plan

- Single fetch, `MEM_LAT`=1: `f_req`=1, `f_addr`=0x40, memory returns 0x8C220004.
  - `mem_re` high at cycle 1.
  - `f_done`=1 with `rdata`=0x8C220004 at cycle 3.
- Simultaneous requests: D load @0x100, S push @0x1FC with data 0x44, and F @0x8, all at cycle 0.
  - Grant order D, S, F.
  - Done pulses at cycles 3, 6 and 9.
  - `mem_we` high only for the S issue, with `mem_wdata`=0x44.
- Starvation, `STARVE_MAX`=2: F held and D re-requesting continuously.
  - F loses two arbitrations, then wins the third.
  - The starve count returns to 0 afterwards.
- Latency sweep: `MEM_LAT`=3, load @0x20.
  - `d_done` exactly 5 cycles after the request cycle.
  - `rdata` equals the memory word; no strobe is repeated during WAIT.
- Reset mid-transaction: `rst_n` pulled low during WAIT.
  - All outputs 0 immediately; no `*_done` pulse.
  - After release, a held `f_req` completes normally with fresh data.
